// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller definitions: the DDR4 command encoding used along the
// whole command path (scheduler, command_sender, dimm_addr_assembler).
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_READ      = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_PRECHARGE = 3'd3,
    CMD_NOP       = 3'd7
  } cmd_e;

  function automatic logic is_rw_cmd(input cmd_e cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/bank_row_table.sv
// Open-page bookkeeping: one open_valid bit and open_row field per bank,
// updated by ACTIVATE (set) and PRECHARGE (clear), with a single lookup port.
module bank_row_table #(
  parameter int NUM_BANKS = 8,
  parameter int IDX_W     = 3,
  parameter int ROW_BITS  = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                set_en,
  input  logic                clr_en,
  input  logic [IDX_W-1:0]    upd_idx,
  input  logic [ROW_BITS-1:0] upd_row,
  input  logic [IDX_W-1:0]    look_idx,
  output logic                open_valid,
  output logic [ROW_BITS-1:0] open_row
);

  logic                open_valid_r [NUM_BANKS];
  logic [ROW_BITS-1:0] open_row_r   [NUM_BANKS];

  // Per-bank open-row state; every bank reads as closed after reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        open_valid_r[i] <= 1'b0;
        open_row_r[i]   <= {ROW_BITS{1'b0}};
      end
    end else if (set_en) begin
      open_valid_r[upd_idx] <= 1'b1;
      open_row_r[upd_idx]   <= upd_row;
    end else if (clr_en) begin
      open_valid_r[upd_idx] <= 1'b0;
    end
  end

  assign open_valid = open_valid_r[look_idx];
  assign open_row   = open_row_r[look_idx];

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Turns one bank/row/column request at a time into PRECHARGE/ACTIVATE/READ/WRITE
// commands, honouring bank latencies, burst spacing and read-to-write turnaround.
module dram_cmd_scheduler
  import mem_ctrl_pkg::*;
#(
  parameter int BANK_GROUPS        = 4,
  parameter int BANKS_PER_GROUP    = 2,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int CAS_LATENCY        = 22,
  parameter int BURST_LEN          = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic                               req_write_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]     req_bg_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] req_ba_in,
  input  logic [ROW_BITS-1:0]                req_row_in,
  input  logic [COL_BITS-1:0]                req_col_in,
  output logic                               cmd_valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bg_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] ba_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [COL_BITS-1:0]                col_out,
  output logic                               req_done_out
);

  localparam int BG_W      = $clog2(BANK_GROUPS);
  localparam int BA_W      = $clog2(BANKS_PER_GROUP);
  localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int IDX_W     = $clog2(NUM_BANKS);
  localparam int CNT_W     = $clog2(CAS_LATENCY + BURST_LEN + 1);
  localparam int WAIT_W    = $clog2(ACTIVATION_LATENCY + PRECHARGE_LATENCY + 1);

  // Reload values count down to zero on the first cycle the next command may issue.
  localparam logic [CNT_W-1:0]  BUS_RELOAD = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  RTW_RELOAD = CNT_W'(CAS_LATENCY + BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] PRE_WAIT   = WAIT_W'(PRECHARGE_LATENCY - 2);
  localparam logic [WAIT_W-1:0] ACT_WAIT   = WAIT_W'(ACTIVATION_LATENCY - 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_WAIT_PRE, ST_ACT, ST_WAIT_ACT, ST_RW
  } state_e;

  function automatic logic [IDX_W-1:0] bank_index(input logic [BG_W-1:0] bg,
                                                  input logic [BA_W-1:0] ba);
    return IDX_W'(bg) * IDX_W'(BANKS_PER_GROUP) + IDX_W'(ba);
  endfunction

  state_e              state_r, state_nxt_s;
  logic [WAIT_W-1:0]   wait_r, wait_nxt_s;
  logic [CNT_W-1:0]    bus_cnt_r, bus_nxt_s;
  logic [CNT_W-1:0]    rtw_cnt_r, rtw_nxt_s;
  logic                lat_write_r, lat_write_nxt_s;
  logic [BG_W-1:0]     lat_bg_r, lat_bg_nxt_s;
  logic [BA_W-1:0]     lat_ba_r, lat_ba_nxt_s;
  logic [ROW_BITS-1:0] lat_row_r, lat_row_nxt_s;
  logic [COL_BITS-1:0] lat_col_r, lat_col_nxt_s;
  logic                ready_r, ready_nxt_s;
  logic                cmd_valid_r, cmd_valid_nxt_s;
  cmd_e                cmd_r, cmd_nxt_s;
  logic [BG_W-1:0]     bg_r, bg_nxt_s;
  logic [BA_W-1:0]     ba_r, ba_nxt_s;
  logic [ROW_BITS-1:0] row_r, row_nxt_s;
  logic [COL_BITS-1:0] col_r, col_nxt_s;
  logic                done_r, done_nxt_s;
  logic                open_valid_s;
  logic [ROW_BITS-1:0] open_row_s;

  bank_row_table #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (IDX_W),
    .ROW_BITS  (ROW_BITS)
  ) u_bank_row_table (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .set_en     (cmd_valid_r && (cmd_r == CMD_ACTIVATE)),
    .clr_en     (cmd_valid_r && (cmd_r == CMD_PRECHARGE)),
    .upd_idx    (bank_index(lat_bg_r, lat_ba_r)),
    .upd_row    (lat_row_r),
    .look_idx   (bank_index(req_bg_in, req_ba_in)),
    .open_valid (open_valid_s),
    .open_row   (open_row_s)
  );

  // Next state, free-running timers and the command to present next cycle.
  always_comb begin
    state_nxt_s     = state_r;
    wait_nxt_s      = wait_r;
    lat_write_nxt_s = lat_write_r;
    lat_bg_nxt_s    = lat_bg_r;
    lat_ba_nxt_s    = lat_ba_r;
    lat_row_nxt_s   = lat_row_r;
    lat_col_nxt_s   = lat_col_r;

    if (cmd_valid_r && is_rw_cmd(cmd_r)) begin
      bus_nxt_s = BUS_RELOAD;
    end else if (bus_cnt_r != {CNT_W{1'b0}}) begin
      bus_nxt_s = bus_cnt_r - CNT_W'(1);
    end else begin
      bus_nxt_s = {CNT_W{1'b0}};
    end

    if (cmd_valid_r && (cmd_r == CMD_READ)) begin
      rtw_nxt_s = RTW_RELOAD;
    end else if (rtw_cnt_r != {CNT_W{1'b0}}) begin
      rtw_nxt_s = rtw_cnt_r - CNT_W'(1);
    end else begin
      rtw_nxt_s = {CNT_W{1'b0}};
    end

    case (state_r)
      ST_IDLE: begin
        if (req_valid_in && ready_r) begin
          lat_write_nxt_s = req_write_in;
          lat_bg_nxt_s    = req_bg_in;
          lat_ba_nxt_s    = req_ba_in;
          lat_row_nxt_s   = req_row_in;
          lat_col_nxt_s   = req_col_in;
          if (open_valid_s && (open_row_s == req_row_in)) begin
            state_nxt_s = ST_RW;
          end else if (open_valid_s) begin
            state_nxt_s = ST_PRE;
          end else begin
            state_nxt_s = ST_ACT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        state_nxt_s = ST_WAIT_PRE;
        wait_nxt_s  = PRE_WAIT;
      end
      ST_WAIT_PRE: begin
        if (wait_r == {WAIT_W{1'b0}}) begin
          state_nxt_s = ST_ACT;
        end else begin
          wait_nxt_s = wait_r - WAIT_W'(1);
        end
      end
      ST_ACT: begin
        state_nxt_s = ST_WAIT_ACT;
        wait_nxt_s  = ACT_WAIT;
      end
      ST_WAIT_ACT: begin
        if (wait_r == {WAIT_W{1'b0}}) begin
          state_nxt_s = ST_RW;
        end else begin
          wait_nxt_s = wait_r - WAIT_W'(1);
        end
      end
      ST_RW: begin
        if (cmd_valid_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RW;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    ready_nxt_s     = (state_nxt_s == ST_IDLE);
    cmd_valid_nxt_s = 1'b0;
    cmd_nxt_s       = CMD_NOP;
    done_nxt_s      = 1'b0;
    case (state_nxt_s)
      ST_PRE: begin
        cmd_valid_nxt_s = 1'b1;
        cmd_nxt_s       = CMD_PRECHARGE;
      end
      ST_ACT: begin
        cmd_valid_nxt_s = 1'b1;
        cmd_nxt_s       = CMD_ACTIVATE;
      end
      ST_RW: begin
        // READ ignores the turnaround timer; WRITE waits for both.
        if ((bus_nxt_s == {CNT_W{1'b0}}) &&
            (!lat_write_nxt_s || (rtw_nxt_s == {CNT_W{1'b0}}))) begin
          cmd_valid_nxt_s = 1'b1;
          cmd_nxt_s       = lat_write_nxt_s ? CMD_WRITE : CMD_READ;
          done_nxt_s      = 1'b1;
        end else begin
          cmd_valid_nxt_s = 1'b0;
        end
      end
      default: cmd_valid_nxt_s = 1'b0;
    endcase

    if (cmd_valid_nxt_s) begin
      bg_nxt_s  = lat_bg_nxt_s;
      ba_nxt_s  = lat_ba_nxt_s;
      row_nxt_s = lat_row_nxt_s;
      col_nxt_s = lat_col_nxt_s;
    end else begin
      bg_nxt_s  = {BG_W{1'b0}};
      ba_nxt_s  = {BA_W{1'b0}};
      row_nxt_s = {ROW_BITS{1'b0}};
      col_nxt_s = {COL_BITS{1'b0}};
    end
  end

  // FSM state, timers, latched request and registered command outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      wait_r      <= {WAIT_W{1'b0}};
      bus_cnt_r   <= {CNT_W{1'b0}};
      rtw_cnt_r   <= {CNT_W{1'b0}};
      lat_write_r <= 1'b0;
      lat_bg_r    <= {BG_W{1'b0}};
      lat_ba_r    <= {BA_W{1'b0}};
      lat_row_r   <= {ROW_BITS{1'b0}};
      lat_col_r   <= {COL_BITS{1'b0}};
      ready_r     <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_r       <= CMD_NOP;
      bg_r        <= {BG_W{1'b0}};
      ba_r        <= {BA_W{1'b0}};
      row_r       <= {ROW_BITS{1'b0}};
      col_r       <= {COL_BITS{1'b0}};
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wait_r      <= wait_nxt_s;
      bus_cnt_r   <= bus_nxt_s;
      rtw_cnt_r   <= rtw_nxt_s;
      lat_write_r <= lat_write_nxt_s;
      lat_bg_r    <= lat_bg_nxt_s;
      lat_ba_r    <= lat_ba_nxt_s;
      lat_row_r   <= lat_row_nxt_s;
      lat_col_r   <= lat_col_nxt_s;
      ready_r     <= ready_nxt_s;
      cmd_valid_r <= cmd_valid_nxt_s;
      cmd_r       <= cmd_nxt_s;
      bg_r        <= bg_nxt_s;
      ba_r        <= ba_nxt_s;
      row_r       <= row_nxt_s;
      col_r       <= col_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign req_ready_out = ready_r;
  assign cmd_valid_out = cmd_valid_r;
  assign cmd_out       = cmd_r;
  assign bg_out        = bg_r;
  assign ba_out        = ba_r;
  assign row_out       = row_r;
  assign col_out       = col_r;
  assign req_done_out  = done_r;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Scoreboard bench: a cycle-level timing model predicts every command at drive
// time; a monitor pops and compares on each cycle the DUT issues one.
module tb_dram_cmd_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       req_valid_in;
  logic       req_ready_out;
  logic       req_write_in;
  logic [1:0] req_bg_in;
  logic [0:0] req_ba_in;
  logic [7:0] req_row_in;
  logic [3:0] req_col_in;
  logic       cmd_valid_out;
  logic [2:0] cmd_out;
  logic [1:0] bg_out;
  logic [0:0] ba_out;
  logic [7:0] row_out;
  logic [3:0] col_out;
  logic       req_done_out;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
    logic [14:0] addr;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic       mdl_open [8];
  logic [7:0] mdl_row  [8];
  int   last_rw = -100;
  int   last_rd = -100;
  int   ready_exp = -1;

  dram_cmd_scheduler dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_write_in  (req_write_in),
    .req_bg_in     (req_bg_in),
    .req_ba_in     (req_ba_in),
    .req_row_in    (req_row_in),
    .req_col_in    (req_col_in),
    .cmd_valid_out (cmd_valid_out),
    .cmd_out       (cmd_out),
    .bg_out        (bg_out),
    .ba_out        (ba_out),
    .row_out       (row_out),
    .col_out       (col_out),
    .req_done_out  (req_done_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] cmd, input logic [14:0] addr, input logic done);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.addr = addr; e.done = done;
    exp_q.push_back(e);
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mdl_open[i] = 1'b0;
      mdl_row[i]  = 8'h00;
    end
    last_rw = -100;
    last_rd = -100;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic do_req(input logic w, input logic [1:0] bg, input logic [0:0] ba,
                        input logic [7:0] row, input logic [3:0] col);
    int k, a, t, rw, idx;
    logic [14:0] addr;
    k = 0;
    while (req_ready_out !== 1'b1 && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= 100) begin
      check_eq("ready_timeout", {31'd0, req_ready_out}, 32'd1);
      return;
    end
    if (ready_exp >= 0) check_eq("ready_cycle", cyc, ready_exp);
    req_valid_in = 1'b1; req_write_in = w;
    req_bg_in = bg; req_ba_in = ba; req_row_in = row; req_col_in = col;
    a = cyc;
    idx = int'(bg) * 2 + int'(ba);
    addr = {bg, ba, row, col};
    t = a + 1;
    if (!(mdl_open[idx] && mdl_row[idx] == row)) begin
      if (mdl_open[idx]) begin
        push(a + 1, 3'd3, addr, 1'b0);
        t = a + 1 + 5;
      end
      push(t, 3'd2, addr, 1'b0);
      t = t + 8;
    end
    rw = max2(t, last_rw + 8);
    if (w) rw = max2(rw, last_rd + 30);
    push(rw, w ? 3'd1 : 3'd0, addr, 1'b1);
    mdl_open[idx] = 1'b1;
    mdl_row[idx]  = row;
    last_rw = rw;
    if (!w) last_rd = rw;
    ready_exp = rw + 1;
    @(negedge clk_in);
    req_valid_in = 1'b0;
  endtask

  // Output monitor: reset values, idle encoding, and scoreboard comparison.
  always @(negedge clk_in) begin
    if (rst_in) begin
      check_eq("reset_outs", {11'd0, req_ready_out, cmd_valid_out, cmd_out,
                              bg_out, ba_out, row_out, col_out, req_done_out},
               {11'd0, 1'b0, 1'b0, 3'd7, 15'd0, 1'b0});
    end else if (cmd_valid_out) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_cmd", {31'd0, cmd_valid_out}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("cmd_cycle", cyc, e.cyc);
        check_eq("cmd_code", {29'd0, cmd_out}, {29'd0, e.cmd});
        check_eq("cmd_addr", {17'd0, bg_out, ba_out, row_out, col_out}, {17'd0, e.addr});
        check_eq("cmd_done", {31'd0, req_done_out}, {31'd0, e.done});
      end
    end else begin
      check_eq("idle_outs", {12'd0, cmd_out, bg_out, ba_out, row_out, col_out, req_done_out},
               {12'd0, 3'd7, 15'd0, 1'b0});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; req_valid_in = 1'b0; req_write_in = 1'b0;
    req_bg_in = 2'd0; req_ba_in = 1'b0; req_row_in = 8'h00; req_col_in = 4'h0;
    model_reset();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    ready_exp = cyc + 1;

    // Cold read, row hit, row conflict.
    do_req(1'b0, 2'd1, 1'b0, 8'h12, 4'd3);
    do_req(1'b0, 2'd1, 1'b0, 8'h12, 4'd5);
    do_req(1'b0, 2'd1, 1'b0, 8'h34, 4'd6);
    // Read-to-write turnaround, then back-to-back write hits.
    do_req(1'b1, 2'd1, 1'b0, 8'h34, 4'd7);
    do_req(1'b1, 2'd1, 1'b0, 8'h34, 4'd8);
    do_req(1'b1, 2'd1, 1'b0, 8'h34, 4'd9);

    // Backpressure: next request held valid while the scheduler waits on ACTIVATE.
    do_req(1'b0, 2'd3, 1'b1, 8'hA0, 4'd2);
    req_valid_in = 1'b1; req_write_in = 1'b1;
    req_bg_in = 2'd0; req_ba_in = 1'b1; req_row_in = 8'h0F; req_col_in = 4'd2;
    for (int i = 0; i < 8; i++) begin
      check_eq("bp_ready", {31'd0, req_ready_out}, 32'd0);
      @(negedge clk_in);
    end
    do_req(1'b1, 2'd0, 1'b1, 8'h0F, 4'd2);
    do_req(1'b0, 2'd0, 1'b1, 8'h0F, 4'd4);

    for (int i = 0; i < 12; i++) begin
      logic [7:0] rsel;
      case ($urandom_range(0, 2))
        0:       rsel = 8'h12;
        1:       rsel = 8'h34;
        default: rsel = 8'h56;
      endcase
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             rsel, 4'($urandom_range(0, 15)));
    end

    // Reset while the bank is mid-activation: no READ may follow.
    do_req(1'b0, 2'd2, 1'b1, 8'h55, 4'd1);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check_eq("rst_async", {11'd0, req_ready_out, cmd_valid_out, cmd_out,
                           bg_out, ba_out, row_out, col_out, req_done_out},
             {11'd0, 1'b0, 1'b0, 3'd7, 15'd0, 1'b0});
    exp_q.delete();
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    ready_exp = cyc + 1;
    do_req(1'b0, 2'd2, 1'b1, 8'h55, 4'd1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_in);
    check_eq("drain", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
